mac_tx_arbiter: RTL and testbench

Frame-level round-robin arbiter that shares the 10G MAC TX AXI-Stream slave port between N_SRC independent packet sources. Sits in the TX clock domain directly upstream of the MAC+PCS top. It grants one source at a time, holds the grant until that source's tlast beat, and drives the MAC through a registered output slice. It never interleaves beats from different frames.

---
 rtl/mac_tx_arbiter_if.sv | 29 ++
 rtl/mac_tx_arbiter.sv | 97 +++++++++
 tb/tb_mac_tx_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_tx_arbiter_if.sv
// AXI-Stream bundle between N_SRC packet sources, the TX arbiter and the MAC slave port.
// slave: arbiter view (takes source beats, drives the MAC side); master: upstream/MAC-side view.
interface mac_tx_arbiter_if #(
  parameter int N_SRC     = 4,
  parameter int N_SYMBOLS = 8,
  parameter int W_SYMBOL  = 8
);
  logic [N_SRC-1:0]                            s_axis_tvalid;
  logic [N_SRC-1:0][N_SYMBOLS*W_SYMBOL-1:0]    s_axis_tdata;
  logic [N_SRC-1:0][N_SYMBOLS-1:0]             s_axis_tkeep;
  logic [N_SRC-1:0]                            s_axis_tlast;
  logic [N_SRC-1:0]                            s_axis_tready;

  logic                                        m_axis_tvalid;
  logic [N_SYMBOLS*W_SYMBOL-1:0]               m_axis_tdata;
  logic [N_SYMBOLS-1:0]                        m_axis_tkeep;
  logic                                        m_axis_tlast;
  logic                                        m_axis_tready;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );
endinterface

// File: rtl/mac_tx_arbiter.sv
// Frame-level round-robin arbiter onto the MAC TX port; 1-cycle arbitration, beat visible the cycle after accept.
// Grant held until tlast; granted source's ready follows the single-entry output slice (stall when full and not drained).
module mac_tx_arbiter #(
  parameter int N_SRC     = 4,
  parameter int N_SYMBOLS = 8,
  parameter int W_SYMBOL  = 8
) (
  input  logic               i_tx_clk,
  input  logic               i_tx_reset,
  input  logic [N_SRC-1:0]   i_src_en,
  mac_tx_arbiter_if.slave    bus,
  output logic [N_SRC-1:0]   o_grant,
  output logic               o_busy
);
  localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic {IDLE, LOCK} state_t;

  typedef struct packed {
    logic [N_SYMBOLS*W_SYMBOL-1:0] tdata;
    logic [N_SYMBOLS-1:0]          tkeep;
    logic                          tlast;
  } beat_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   g, last_grant, pick, cand;
  logic [N_SRC-1:0] req;
  logic            rdy_g, accept, accept_last;
  beat_t           out_beat;
  logic            out_vld;

  assign req         = bus.s_axis_tvalid & i_src_en;
  assign rdy_g       = !out_vld || bus.m_axis_tready;
  assign accept      = (state == LOCK) && bus.s_axis_tvalid[g] && rdy_g;
  assign accept_last = accept && bus.s_axis_tlast[g];

  // Walk downward so the requester closest above last_grant overwrites the rest.
  always_comb begin
    pick = last_grant;
    cand = '0;
    for (int i = N_SRC; i >= 1; i--) begin
      cand = GW'((int'(last_grant) + i) % N_SRC);
      if (req[cand]) pick = cand;
    end
  end

  always_ff @(posedge i_tx_clk or posedge i_tx_reset) begin
    if (i_tx_reset) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = LOCK;
      LOCK:    if (accept_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.s_axis_tready = '0;
    o_grant           = '0;
    o_busy            = 1'b0;
    if (state == LOCK) begin
      bus.s_axis_tready[g] = rdy_g;
      o_grant[g]           = 1'b1;
      o_busy               = 1'b1;
    end
  end

  always_ff @(posedge i_tx_clk or posedge i_tx_reset) begin
    if (i_tx_reset) begin
      g          <= '0;
      last_grant <= GW'(N_SRC - 1);
      out_vld    <= 1'b0;
      out_beat   <= '0;
    end else begin
      if (state == IDLE && |req) g <= pick;
      if (accept_last) last_grant <= g;
      // A fresh beat wins over a drain on the same edge, keeping the slice full.
      if (accept) begin
        out_vld        <= 1'b1;
        out_beat.tdata <= bus.s_axis_tdata[g];
        out_beat.tkeep <= bus.s_axis_tkeep[g];
        out_beat.tlast <= bus.s_axis_tlast[g];
      end else if (bus.m_axis_tready) begin
        out_vld <= 1'b0;
      end
    end
  end

  assign bus.m_axis_tvalid = out_vld;
  assign bus.m_axis_tdata  = out_beat.tdata;
  assign bus.m_axis_tkeep  = out_beat.tkeep;
  assign bus.m_axis_tlast  = out_beat.tlast;
endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Randomized bench for mac_tx_arbiter: frame-level round-robin model feeds a scoreboard
// that a negedge monitor drains against every MAC-side handshake.
`timescale 1ns/1ps
module tb_mac_tx_arbiter;
  localparam int N = 4;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] src_en;
  logic [N-1:0] grant;
  logic         busy;

  mac_tx_arbiter_if #(.N_SRC(N), .N_SYMBOLS(8), .W_SYMBOL(8)) bus ();

  mac_tx_arbiter #(.N_SRC(N), .N_SYMBOLS(8), .W_SYMBOL(8)) dut (
    .i_tx_clk   (clk),
    .i_tx_reset (rst),
    .i_src_en   (src_en),
    .bus        (bus),
    .o_grant    (grant),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int      checks = 0;
  int      errors = 0;
  beat_t   srcq [N][$];
  beat_t   mq   [N][$];
  beat_t   exp_q[$];
  int      model_last = N - 1;
  int      gap  [N];
  logic [N-1:0] acc_s = '0;
  int      rdy_mode = 0;
  bit      gap_en = 1'b0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic add_frame(input int s, input int len, input logic [7:0] last_keep);
    beat_t x;
    for (int b = 0; b < len; b++) begin
      x.d = {$urandom, $urandom};
      x.l = (b == len - 1);
      x.k = x.l ? last_keep : 8'hFF;
      srcq[s].push_back(x);
      mq[s].push_back(x);
    end
  endtask

  // Every enabled source with frames left is requesting at each arbitration,
  // so the frame order is plain round robin over the enabled, non-empty sources.
  task automatic run_model(input logic [N-1:0] en);
    bit    found;
    int    s;
    beat_t x;
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      for (int i = 1; i <= N; i++) begin
        s = (model_last + i) % N;
        if (!found && en[s] && mq[s].size() > 0) begin
          found      = 1'b1;
          model_last = s;
          do begin
            x = mq[s].pop_front();
            exp_q.push_back(x);
          end while (!x.l);
        end
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || bus.m_axis_tvalid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    #2;
    chk(n < 3000, "drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_mv();
    int n;
    n = 0;
    while (!bus.m_axis_tvalid && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(n < 500, "wait_out_valid", 64'(n), 64'd500);
  endtask

  task automatic wait_grant(input logic [N-1:0] want);
    int n;
    n = 0;
    while (grant != want && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(grant == want, "wait_grant", 64'(grant), 64'(want));
  endtask

  // Source and MAC-ready driver, one step after every rising edge.
  initial begin
    beat_t x;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = '0;
    bus.s_axis_tlast  = '0;
    bus.m_axis_tready = 1'b0;
    for (int s = 0; s < N; s++) gap[s] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int s = 0; s < N; s++) begin
        if (acc_s[s] && srcq[s].size() > 0) begin
          x = srcq[s].pop_front();
          if (!x.l && gap_en && $urandom_range(0, 2) == 0) gap[s] = $urandom_range(1, 3);
        end
        if (gap[s] > 0) begin
          bus.s_axis_tvalid[s] = 1'b0;
          gap[s]--;
        end else if (srcq[s].size() > 0) begin
          bus.s_axis_tvalid[s] = 1'b1;
          bus.s_axis_tdata[s]  = srcq[s][0].d;
          bus.s_axis_tkeep[s]  = srcq[s][0].k;
          bus.s_axis_tlast[s]  = srcq[s][0].l;
        end else begin
          bus.s_axis_tvalid[s] = 1'b0;
        end
      end
      case (rdy_mode)
        0:       bus.m_axis_tready = 1'b1;
        1:       bus.m_axis_tready = ($urandom_range(0, 3) != 0);
        default: bus.m_axis_tready = 1'b0;
      endcase
    end
  end

  // Monitor: protocol rules and scoreboard, sampled on the falling edge.
  initial begin
    logic [N-1:0] p_grant, exp_rdy;
    logic         p_busy, p_mv, p_mr, p_ml, p_rst, p_req_idle, p_tlast_acc;
    logic [63:0]  p_md;
    logic [7:0]   p_mk;
    beat_t        x;
    p_grant = '0; p_busy = 1'b0; p_mv = 1'b0; p_mr = 1'b0; p_ml = 1'b0;
    p_rst = 1'b1; p_req_idle = 1'b0; p_tlast_acc = 1'b0; p_md = '0; p_mk = '0;
    forever begin
      @(negedge clk);
      acc_s = bus.s_axis_tvalid & bus.s_axis_tready;
      if (!rst) begin
        chk($onehot0(grant) && (busy == (grant != '0)), "grant_onehot", 64'(grant), 64'(busy));
        exp_rdy = '0;
        for (int s = 0; s < N; s++)
          if (busy && grant[s]) exp_rdy[s] = !bus.m_axis_tvalid || bus.m_axis_tready;
        chk(bus.s_axis_tready == exp_rdy, "src_ready", 64'(bus.s_axis_tready), 64'(exp_rdy));
        if (!p_rst) begin
          if (p_req_idle)  chk(busy, "arb_latency", 64'(busy), 64'd1);
          if (p_tlast_acc) chk(!busy && grant == '0, "frame_bubble", 64'(grant), 64'd0);
          if (p_busy && !p_tlast_acc) chk(grant == p_grant, "grant_hold", 64'(grant), 64'(p_grant));
          if (p_mv && !p_mr)
            chk(bus.m_axis_tvalid && bus.m_axis_tdata == p_md && bus.m_axis_tkeep == p_mk &&
                bus.m_axis_tlast == p_ml, "out_stable", bus.m_axis_tdata, p_md);
        end
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
          if (exp_q.size() == 0) begin
            chk(1'b0 == bus.m_axis_tvalid, "unexpected_beat", bus.m_axis_tdata, 64'd0);
          end else begin
            x = exp_q.pop_front();
            chk(bus.m_axis_tdata == x.d, "beat_data", bus.m_axis_tdata, x.d);
            chk({bus.m_axis_tkeep, bus.m_axis_tlast} == {x.k, x.l}, "beat_keep_last",
                64'({bus.m_axis_tkeep, bus.m_axis_tlast}), 64'({x.k, x.l}));
          end
        end
      end
      p_rst       = rst;
      p_grant     = grant;
      p_busy      = busy;
      p_mv        = bus.m_axis_tvalid;
      p_mr        = bus.m_axis_tready;
      p_md        = bus.m_axis_tdata;
      p_mk        = bus.m_axis_tkeep;
      p_ml        = bus.m_axis_tlast;
      p_req_idle  = !busy && ((bus.s_axis_tvalid & src_en) != '0);
      p_tlast_acc = busy && ((acc_s & grant & bus.s_axis_tlast) != '0);
    end
  end

  initial begin
    src_en = '1;
    #1;
    chk(!bus.m_axis_tvalid && !bus.m_axis_tlast, "reset_out_ctl", 64'({bus.m_axis_tvalid, bus.m_axis_tlast}), 64'd0);
    chk(bus.m_axis_tdata == '0 && bus.m_axis_tkeep == '0, "reset_out_dat", bus.m_axis_tdata, 64'd0);
    chk(bus.s_axis_tready == '0, "reset_src_ready", 64'(bus.s_axis_tready), 64'd0);
    chk(grant == '0 && !busy, "reset_grant_busy", 64'({grant, busy}), 64'd0);
    #22 rst = 1'b0;

    // Lone 3-beat frame with a partial last keep.
    @(negedge clk); #2;
    add_frame(0, 3, 8'h0F);
    run_model(src_en);
    drain();

    // Five-cycle MAC stall in the middle of a frame.
    add_frame(2, 5, 8'h03);
    run_model(src_en);
    wait_mv();
    #2 rdy_mode = 2;
    repeat (5) @(negedge clk);
    #2 rdy_mode = 0;
    drain();

    // All sources back to back with 2-beat frames.
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < N; s++) add_frame(s, 2, 8'($urandom_range(1, 255)));
    run_model(src_en);
    drain();

    // Random lengths, mid-frame source gaps, random MAC backpressure.
    gap_en   = 1'b1;
    rdy_mode = 1;
    for (int r = 0; r < 6; r++)
      for (int s = 0; s < N; s++) add_frame(s, $urandom_range(1, 5), 8'($urandom_range(1, 255)));
    run_model(src_en);
    drain();

    // Only 1 and 3 enabled while all request; source 1 disabled during its own frame.
    src_en = 4'b1010;
    add_frame(0, 2, 8'h01);
    add_frame(2, 2, 8'h07);
    add_frame(1, 4, 8'h3F);
    add_frame(3, 2, 8'hFF);
    add_frame(3, 3, 8'h1F);
    run_model(src_en);
    wait_grant(4'b0010);
    #2 src_en = 4'b1000;
    drain();

    // Re-enable: the parked sources 0 and 2 go out in round-robin order.
    src_en = '1;
    run_model(src_en);
    drain();

    // Asynchronous reset in the middle of a frame.
    rdy_mode = 0;
    gap_en   = 1'b0;
    add_frame(0, 8, 8'hFF);
    run_model(src_en);
    wait_mv();
    #3 rst = 1'b1;
    #1;
    chk(!bus.m_axis_tvalid, "async_reset_out", 64'(bus.m_axis_tvalid), 64'd0);
    chk(grant == '0 && !busy, "async_reset_grant", 64'({grant, busy}), 64'd0);
    exp_q.delete();
    srcq[0].delete();
    acc_s = '0;
    for (int s = 0; s < N; s++) gap[s] = 0;
    model_last = N - 1;
    @(posedge clk);
    @(negedge clk);
    #3 rst = 1'b0;
    add_frame(2, 2, 8'hFF);
    add_frame(0, 3, 8'h01);
    run_model(src_en);
    wait_grant(4'b0001);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
